hdmi_pattern_gen: RTL and testbench



---
 rtl/hdmi_video_pkg.sv | 44 ++++
 rtl/hdmi_pattern_gen_if.sv | 31 +++
 rtl/hdmi_pattern_color.sv | 64 ++++++
 rtl/hdmi_pattern_gen.sv | 107 ++++++++++
 tb/tb_hdmi_pattern_gen.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_video_pkg.sv
// hdmi_video_pkg: shared 720p geometry, pattern mode codes
// and colour constants for the video path.
package hdmi_video_pkg;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_CNT_W    = 11;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_e;

  typedef logic [23:0] rgb_t;

  localparam rgb_t COL_SOLID   = 24'hFF6432;
  localparam rgb_t COL_WHITE   = 24'hFFFFFF;
  localparam rgb_t COL_YELLOW  = 24'hFFFF00;
  localparam rgb_t COL_CYAN    = 24'h00FFFF;
  localparam rgb_t COL_GREEN   = 24'h00FF00;
  localparam rgb_t COL_MAGENTA = 24'hFF00FF;
  localparam rgb_t COL_RED     = 24'hFF0000;
  localparam rgb_t COL_BLUE    = 24'h0000FF;
  localparam rgb_t COL_BLACK   = 24'h000000;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    c = COL_BLACK;
    unique case (idx)
      3'd0: c = COL_WHITE;
      3'd1: c = COL_YELLOW;
      3'd2: c = COL_CYAN;
      3'd3: c = COL_GREEN;
      3'd4: c = COL_MAGENTA;
      3'd5: c = COL_RED;
      3'd6: c = COL_BLUE;
      3'd7: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_pattern_gen_if.sv
// hdmi_pattern_gen_if: timing stream in, RGB video out,
// plus the mode control strobe.
interface hdmi_pattern_gen_if;

  logic [1:0]  mode_sel;
  logic        mode_load;
  logic        hsync_in;
  logic        vsync_in;
  logic        de_in;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;
  logic [23:0] rgb_out;
  logic        frame_start;
  logic [1:0]  active_mode;

  modport master (
    output mode_sel, mode_load,
    output hsync_in, vsync_in, de_in,
    input  hsync_out, vsync_out, de_out,
    input  rgb_out, frame_start, active_mode
  );

  modport slave (
    input  mode_sel, mode_load,
    input  hsync_in, vsync_in, de_in,
    output hsync_out, vsync_out, de_out,
    output rgb_out, frame_start, active_mode
  );

endinterface

// File: rtl/hdmi_pattern_color.sv
// hdmi_pattern_color: stage 2, registers the pattern colour.
// PATTERN_BORDER_EN adds a white frame border.
module hdmi_pattern_color
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] x_i,
  input  logic [CNT_W-1:0] y_i,
  input  logic             de_i,
  input  mode_e            mode_i,
  output rgb_t             rgb_o
);

  logic [2:0] bar_idx;
  rgb_t       pat;
  rgb_t       rgb_d;
  rgb_t       rgb_q;

  // Threshold chain; saturates at bar 7 past the active width.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_i >= CNT_W'(i * (H_ACTIVE / 8)))
        bar_idx = 3'(i);
    end
  end

  always_comb begin
    pat = COL_BLACK;
    unique case (mode_i)
      MODE_SOLID: pat = COL_SOLID;
      MODE_BARS:  pat = bar_color(bar_idx);
      MODE_CHECK: pat = (x_i[5] ^ y_i[5]) ? COL_WHITE
                                          : COL_BLACK;
      MODE_RAMP:  pat = {3{x_i[9:2]}};
    endcase
    rgb_d = de_i ? pat : COL_BLACK;
`ifdef PATTERN_BORDER_EN
    if (de_i && ((x_i == '0) ||
                 (x_i == CNT_W'(H_ACTIVE - 1)) ||
                 (y_i == '0) ||
                 (y_i == CNT_W'(V_ACTIVE - 1))))
      rgb_d = COL_WHITE;
`endif
  end

`ifndef PATTERN_BORDER_EN
  logic unused_y;
  assign unused_y = ^{y_i, V_ACTIVE[0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= COL_BLACK;
    else        rgb_q <= rgb_d;
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: coordinates, frame-synchronous mode shadow
// and 2-cycle sync delay; PATTERN_BORDER_EN enables the border.
module hdmi_pattern_gen
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic               clock74,
  input  logic               reset,
  hdmi_pattern_gen_if.slave  vif
);

  logic             de_prev_q;
  logic             vs_prev_q;
  logic             vs_rise;
  logic             de_fall;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  mode_e            pend_q, pend_d;
  mode_e            act_q, act_d;
  logic             fs_q;
  logic [CNT_W-1:0] s1_x_q, s1_y_q;
  logic             s1_de_q, s1_hs_q, s1_vs_q;
  mode_e            s1_mode_q;
  logic             s2_de_q, s2_hs_q, s2_vs_q;
  rgb_t             rgb;

  assign vs_rise = vif.vsync_in & ~vs_prev_q;
  assign de_fall = de_prev_q & ~vif.de_in;

  always_comb begin
    x_d = '0;
    if (vif.de_in)
      x_d = (&x_q) ? x_q : x_q + 1'b1;
    y_d = y_q;
    if (vs_rise)
      y_d = '0;
    else if (de_fall && !(&y_q))
      y_d = y_q + 1'b1;
    pend_d = vif.mode_load ? mode_e'(vif.mode_sel)
                           : pend_q;
    // Taking pend_d gives the load/vsync bypass for free.
    act_d = vs_rise ? pend_d : act_q;
  end

  always_ff @(posedge clock74 or negedge reset) begin
    if (!reset) begin
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      pend_q    <= MODE_SOLID;
      act_q     <= MODE_SOLID;
      fs_q      <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_de_q   <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_mode_q <= MODE_SOLID;
      s2_de_q   <= 1'b0;
      s2_hs_q   <= 1'b0;
      s2_vs_q   <= 1'b0;
    end else begin
      de_prev_q <= vif.de_in;
      vs_prev_q <= vif.vsync_in;
      x_q       <= x_d;
      y_q       <= y_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      fs_q      <= vs_rise;
      s1_x_q    <= x_q;
      s1_y_q    <= y_q;
      s1_de_q   <= vif.de_in;
      s1_hs_q   <= vif.hsync_in;
      s1_vs_q   <= vif.vsync_in;
      s1_mode_q <= act_q;
      s2_de_q   <= s1_de_q;
      s2_hs_q   <= s1_hs_q;
      s2_vs_q   <= s1_vs_q;
    end
  end

  hdmi_pattern_color #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CNT_W    (CNT_W)
  ) u_color (
    .clk    (clock74),
    .rst_n  (reset),
    .x_i    (s1_x_q),
    .y_i    (s1_y_q),
    .de_i   (s1_de_q),
    .mode_i (s1_mode_q),
    .rgb_o  (rgb)
  );

  assign vif.hsync_out   = s2_hs_q;
  assign vif.vsync_out   = s2_vs_q;
  assign vif.de_out      = s2_de_q;
  assign vif.rgb_out     = rgb;
  assign vif.frame_start = fs_q;
  assign vif.active_mode = act_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb_hdmi_pattern_gen: directed checks of hdmi_pattern_gen.
`timescale 1ns/1ps
module tb_hdmi_pattern_gen;
  import hdmi_video_pkg::*;

`ifdef PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hdmi_pattern_gen_if vif ();

  hdmi_pattern_gen dut (
    .clock74 (clk),
    .reset   (rst_n),
    .vif     (vif)
  );

  int checks = 0;
  int errors = 0;
  logic [23:0] cap [2048];
  logic        cap_de [2048];
  logic [23:0] pre_rgb;
  int cur_y = 0;
  int line_y = 0;
  int fs_cnt = 0;
  int bad = 0;
  logic [1:0] mode_at_edge;
  int pat_de [9] = '{1, 0, 1, 1, 0, 1, 1, 0, 0};
  int pat_hs [9] = '{0, 1, 1, 0, 0, 1, 0, 1, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ex(input int x, input int y,
                                     input logic [23:0] c);
    if (BORDER && (x == 0 || x == DEF_H_ACTIVE - 1 ||
                   y == 0 || y == DEF_V_ACTIVE - 1))
      return 24'hFFFFFF;
    return c;
  endfunction

  task automatic run_line(input int npix, input int nblank);
    line_y = cur_y;
    for (int c = 0; c < npix + nblank; c++) begin
      vif.de_in = (c < npix);
      tick();
      if (c == 0) pre_rgb = vif.rgb_out;
      else begin
        cap[c-1]    = vif.rgb_out;
        cap_de[c-1] = vif.de_out;
      end
    end
    vif.de_in = 1'b0;
    cur_y++;
  endtask

  task automatic vsync(input logic ld, input logic [1:0] sel);
    fs_cnt = 0;
    vif.de_in = 1'b0;
    vif.mode_sel = sel;
    for (int c = 0; c < 6; c++) begin
      vif.vsync_in  = (c < 3);
      vif.mode_load = ld && (c == 0);
      tick();
      if (vif.frame_start) fs_cnt++;
      if (c == 0) mode_at_edge = vif.active_mode;
    end
    vif.vsync_in  = 1'b0;
    vif.mode_load = 1'b0;
    cur_y = 0;
  endtask

  task automatic load(input logic [1:0] s);
    vif.mode_sel  = s;
    vif.mode_load = 1'b1;
    tick();
    vif.mode_load = 1'b0;
  endtask

  function automatic logic [29:0] outs();
    return {vif.hsync_out, vif.vsync_out, vif.de_out,
            vif.frame_start, vif.active_mode, vif.rgb_out};
  endfunction

  initial begin
    vif.mode_sel  = 2'd0;
    vif.mode_load = 1'b0;
    vif.hsync_in  = 1'b0;
    vif.vsync_in  = 1'b0;
    vif.de_in     = 1'b0;

    // Reset held with toggling inputs
    for (int c = 0; c < 10; c++) begin
      vif.de_in     = c[0];
      vif.hsync_in  = c[1];
      vif.vsync_in  = ~c[0];
      vif.mode_load = 1'b1;
      vif.mode_sel  = 2'd2;
      tick();
      chk("reset_outs", 32'(outs()), 32'd0);
    end
    vif.de_in     = 1'b0;
    vif.hsync_in  = 1'b0;
    vif.vsync_in  = 1'b0;
    vif.mode_load = 1'b0;
    #2 rst_n = 1'b1;

    // Sync/DE latency of 2 cycles
    for (int c = 0; c < 9; c++) begin
      vif.de_in    = pat_de[c][0];
      vif.hsync_in = pat_hs[c][0];
      tick();
      if (c == 0)
        chk("delay_first", {30'd0, vif.hsync_out, vif.de_out}, 32'd0);
      else
        chk("delay_de_hs", {30'd0, vif.hsync_out, vif.de_out},
            {30'd0, pat_hs[c-1][0], pat_de[c-1][0]});
    end
    vif.hsync_in = 1'b0;
    chk("mode_after_rst", 32'(vif.active_mode), 32'd0);

    // Mode 0 solid
    vsync(1'b0, 2'd0);
    chk("fs_solid", fs_cnt, 1);
    chk("mode_solid", 32'(vif.active_mode), 32'd0);
    run_line(1280, 6);
    chk("solid_pre", 32'(pre_rgb), 32'd0);
    bad = 0;
    for (int i = 0; i < 1280; i++)
      if (cap[i] !== ex(i, line_y, COL_SOLID) || cap_de[i] !== 1'b1)
        bad++;
    for (int i = 1280; i < 1285; i++)
      if (cap[i] !== 24'd0 || cap_de[i] !== 1'b0)
        bad++;
    chk("solid_line_bad", bad, 0);

    // Mode 1 bars
    load(2'd1);
    chk("bars_pending", 32'(vif.active_mode), 32'd0);
    vsync(1'b0, 2'd1);
    chk("fs_bars", fs_cnt, 1);
    chk("mode_bars", 32'(vif.active_mode), 32'd1);
    run_line(1280, 6);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (cap[i] !== ex(i, line_y, COL_WHITE)) bad++;
    chk("bars_white_bad", bad, 0);
    chk("bar_160", 32'(cap[160]), 32'(COL_YELLOW));
    chk("bar_320", 32'(cap[320]), 32'(COL_CYAN));
    chk("bar_480", 32'(cap[480]), 32'(COL_GREEN));
    chk("bar_640", 32'(cap[640]), 32'(COL_MAGENTA));
    chk("bar_959", 32'(cap[959]), 32'(COL_RED));
    chk("bar_960", 32'(cap[960]), 32'(COL_BLUE));
    chk("bar_1119", 32'(cap[1119]), 32'(COL_BLUE));
    bad = 0;
    for (int i = 1120; i < 1280; i++)
      if (cap[i] !== ex(i, line_y, COL_BLACK)) bad++;
    chk("bars_black_bad", bad, 0);
    // Over-long DE: clamps to the last bar
    run_line(1300, 6);
    chk("long_clamp", 32'(cap[1290]), 32'(COL_BLACK));
    chk("long_de_in", 32'(cap_de[1299]), 32'd1);
    chk("long_de_end", 32'(cap_de[1300]), 32'd0);

    // Mode 2 checkerboard
    load(2'd2);
    vsync(1'b0, 2'd2);
    chk("mode_check", 32'(vif.active_mode), 32'd2);
    run_line(64, 4);
    chk("chk_31_0", 32'(cap[31]), 32'(ex(31, 0, COL_BLACK)));
    chk("chk_32_0", 32'(cap[32]), 32'(ex(32, 0, COL_WHITE)));
    for (int l = 1; l <= 32; l++) begin
      run_line(64, 4);
      if (line_y == 10)
        chk("chk_0_10", 32'(cap[0]), 32'(ex(0, 10, COL_BLACK)));
    end
    chk("chk_y32", line_y, 32);
    chk("chk_32_32", 32'(cap[32]), 32'(COL_BLACK));
    chk("chk_31_32", 32'(cap[31]), 32'(COL_WHITE));

    // Mid-frame load of mode 3
    load(2'd3);
    tick();
    tick();
    chk("mid_pending", 32'(vif.active_mode), 32'd2);
    run_line(64, 4);
    chk("mid_still_chk", 32'(cap[32]), 32'(COL_BLACK));
    vsync(1'b0, 2'd3);
    chk("fs_ramp", fs_cnt, 1);
    chk("mode_ramp", 32'(vif.active_mode), 32'd3);
    run_line(1280, 6);
    chk("ramp_4", 32'(cap[4]), 32'(ex(4, 0, 24'h010101)));
    chk("ramp_1023", 32'(cap[1023]), 32'(ex(1023, 0, 24'hFFFFFF)));
    chk("ramp_1024", 32'(cap[1024]), 32'(ex(1024, 0, 24'h000000)));
    chk("ramp_1028", 32'(cap[1028]), 32'(ex(1028, 0, 24'h010101)));

    // Load coincident with vsync rise
    vsync(1'b1, 2'd1);
    chk("bypass_mode", 32'(mode_at_edge), 32'd1);
    chk("fs_bypass", fs_cnt, 1);
    run_line(1280, 6);
    chk("bypass_x1", 32'(cap[1]), 32'(COL_WHITE));
    chk("bypass_x1000", 32'(cap[1000]), 32'(COL_BLUE));

    // Asynchronous reset mid-line
    vif.de_in = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_reset_de", 32'(vif.de_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(outs()), 32'd0);
    tick();
    vif.de_in = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("mode_after_rst2", 32'(vif.active_mode), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
